// File: rtl/d_mem_resp.sv
// d_mem_resp: data-memory responder with word RAM and, when DMEM_TIMER_EN is defined,
// a memory-mapped 64-bit machine timer (mtime/mtimecmp/status) driving o_timer_irq.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef D_ADD_SIZE
`define D_ADD_SIZE 32
`endif
module d_mem_resp #(
    parameter int WIDTH = `WIDTH,
    parameter int DEPTH = 256
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_we,
    input  logic [`D_ADD_SIZE-1:0] i_d_add,
    input  logic [WIDTH-1:0]       i_w_data,
    output logic [WIDTH-1:0]       o_r_data,
    output logic                   o_timer_irq
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic             mmio_sel;
    logic [AW-1:0]    idx;
    logic [31:0]      mmio_word;
    logic             unused_bits;
    assign mmio_sel = i_d_add[`D_ADD_SIZE-1];
    assign idx      = i_d_add[AW+1:2];
    always_ff @(posedge i_clk) begin
        if (i_we && !mmio_sel) mem[idx] <= i_w_data;
    end
`ifdef DMEM_TIMER_EN
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic        irq_q, irq_d;
    logic [2:0]  reg_sel;
    logic        wr;
    assign reg_sel     = i_d_add[4:2];
    assign wr          = i_we && mmio_sel;
    assign unused_bits = ^{i_d_add, i_w_data};
    // A write to either mtime half freezes the whole counter for that cycle
    always_comb begin
        mtime_d    = (wr && reg_sel == 3'd0) ? {mtime_q[63:32], i_w_data[31:0]} :
                     (wr && reg_sel == 3'd1) ? {i_w_data[31:0], mtime_q[31:0]} :
                     mtime_q + 64'd1;
        mtimecmp_d = (wr && reg_sel == 3'd2) ? {mtimecmp_q[63:32], i_w_data[31:0]} :
                     (wr && reg_sel == 3'd3) ? {i_w_data[31:0], mtimecmp_q[31:0]} :
                     mtimecmp_q;
        irq_d      = mtime_q >= mtimecmp_q;
        mmio_word  = (reg_sel == 3'd0) ? mtime_q[31:0] :
                     (reg_sel == 3'd1) ? mtime_q[63:32] :
                     (reg_sel == 3'd2) ? mtimecmp_q[31:0] :
                     (reg_sel == 3'd3) ? mtimecmp_q[63:32] :
                     (reg_sel == 3'd4) ? {31'd0, irq_q} : 32'd0;
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end
    assign o_timer_irq = irq_q;
`else
    assign mmio_word   = 32'd0;
    assign o_timer_irq = 1'b0;
    assign unused_bits = ^{i_d_add, i_w_data, i_rstn};
`endif
    assign o_r_data = mmio_sel ? WIDTH'(mmio_word) : mem[idx];
endmodule

// File: tb/tb_d_mem_resp.sv
// tb_d_mem_resp: directed vector table for RAM behaviour plus hand sequences for the timer
// (or for the timer-less build when DMEM_TIMER_EN is undefined).
module tb_d_mem_resp;
    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_we = 1'b0;
    logic [31:0] i_d_add = '0;
    logic [31:0] i_w_data = '0;
    logic [31:0] o_r_data;
    logic        o_timer_irq;
    int checks = 0;
    int errors = 0;

    d_mem_resp dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_we(i_we), .i_d_add(i_d_add),
        .i_w_data(i_w_data), .o_r_data(o_r_data), .o_timer_irq(o_timer_irq)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t v[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // inputs change on the falling edge and are sampled 1 time unit later
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge i_clk);
        i_we = we;
        i_d_add = a;
        i_w_data = d;
        #1;
    endtask

    localparam logic [31:0] MT_LO = 32'h8000_0000, MT_HI = 32'h8000_0004;
    localparam logic [31:0] CMP_LO = 32'h8000_0008, CMP_HI = 32'h8000_000C, STAT = 32'h8000_0010;

    initial begin
        v[0] = '{1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0, 32'h0};
        v[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
        v[2] = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        v[3] = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
        v[4] = '{1'b1, 32'h0000_0400, 32'h0000_1234, 1'b0, 32'h0};
        v[5] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_1234};
        v[6] = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'h0};
        v[7] = '{1'b0, 32'h0000_07FC, 32'h0,         1'b1, 32'hA5A5_A5A5};
        v[8] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0};
        v[9] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_1234};
        repeat (3) @(negedge i_clk);
        chk("reset_irq", {31'd0, o_timer_irq}, 32'd0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        i_d_add = MT_LO;
        #1;
`ifdef DMEM_TIMER_EN
        chk("mtime_after_reset", o_r_data, 32'd0);
        drive(1'b0, MT_LO, 32'd0);
        chk("mtime_incr", o_r_data, 32'd1);
        drive(1'b0, CMP_LO, 32'd0);
        chk("cmp_lo_reset", o_r_data, 32'hFFFF_FFFF);
        drive(1'b0, CMP_HI, 32'd0);
        chk("cmp_hi_reset", o_r_data, 32'hFFFF_FFFF);
        drive(1'b0, MT_HI, 32'd0);
        chk("mtime_hi_reset", o_r_data, 32'd0);
        drive(1'b0, STAT, 32'd0);
        chk("status_reset", o_r_data, 32'd0);
`else
        chk("mmio_lo_off", o_r_data, 32'd0);
        drive(1'b0, CMP_LO, 32'd0);
        chk("mmio_cmp_off", o_r_data, 32'd0);
`endif
        for (int i = 0; i < 10; i++) begin
            drive(v[i].we, v[i].a, v[i].d);
            if (v[i].chk) chk($sformatf("ram_vec%0d", i), o_r_data, v[i].exp);
            chk($sformatf("irq_vec%0d", i), {31'd0, o_timer_irq}, 32'd0);
        end
`ifdef DMEM_TIMER_EN
        drive(1'b1, MT_HI, 32'd0);
        drive(1'b1, MT_LO, 32'hFFFF_FFFE);
        drive(1'b0, MT_LO, 32'd0);
        chk("cnt_lo_loaded", o_r_data, 32'hFFFF_FFFE);
        drive(1'b0, MT_HI, 32'd0);
        chk("cnt_hi_before_carry", o_r_data, 32'd0);
        drive(1'b0, MT_HI, 32'd0);
        chk("cnt_hi_carry", o_r_data, 32'd1);
        drive(1'b0, MT_LO, 32'd0);
        chk("cnt_lo_wrapped", o_r_data, 32'd1);
        drive(1'b1, MT_HI, 32'd0);
        drive(1'b1, MT_LO, 32'd0);
        drive(1'b1, CMP_HI, 32'd0);
        drive(1'b1, CMP_LO, 32'd50);
        begin
            logic [31:0] m_exp;
            logic        irq_exp, irq_nxt;
            m_exp = 32'd2;
            irq_exp = 1'b0;
            while (m_exp <= 32'd54) begin
                drive(1'b0, MT_LO, 32'd0);
                chk($sformatf("irq_mtime%0d", m_exp), o_r_data, m_exp);
                chk($sformatf("irq_at%0d", m_exp), {31'd0, o_timer_irq}, {31'd0, irq_exp});
                irq_nxt = m_exp >= 32'd50;
                m_exp++;
                irq_exp = irq_nxt;
            end
        end
        drive(1'b1, CMP_HI, 32'd1);
        chk("irq_hold_on_write", {31'd0, o_timer_irq}, 32'd1);
        drive(1'b0, STAT, 32'd0);
        chk("status_still_high", o_r_data, 32'd1);
        chk("irq_still_high", {31'd0, o_timer_irq}, 32'd1);
        drive(1'b0, STAT, 32'd0);
        chk("status_dropped", o_r_data, 32'd0);
        chk("irq_dropped", {31'd0, o_timer_irq}, 32'd0);
        drive(1'b1, CMP_HI, 32'd0);
        drive(1'b0, STAT, 32'd0);
        chk("irq_rearm_wait", {31'd0, o_timer_irq}, 32'd0);
        drive(1'b0, STAT, 32'd0);
        chk("irq_rearmed", {31'd0, o_timer_irq}, 32'd1);
        chk("status_rearmed", o_r_data, 32'd1);
        @(negedge i_clk);
        i_rstn = 1'b0;
        i_d_add = MT_LO;
        #1;
        chk("midrst_irq", {31'd0, o_timer_irq}, 32'd0);
        chk("midrst_mtime", o_r_data, 32'd0);
        i_d_add = CMP_LO;
        #1;
        chk("midrst_cmp", o_r_data, 32'hFFFF_FFFF);
        @(negedge i_clk);
        i_rstn = 1'b1;
`else
        for (int i = 0; i < 1000; i++) begin
            drive(i % 3 == 0, 32'h8000_0000 + 32'(4 * (i % 8)), 32'(i) * 32'h0101_0101);
            chk("mmio_off_read", o_r_data, 32'd0);
            chk("irq_off", {31'd0, o_timer_irq}, 32'd0);
        end
`endif
        drive(1'b0, 32'h0000_0010, 32'd0);
        chk("ram_kept_10", o_r_data, 32'hDEAD_BEEF);
        drive(1'b0, 32'h0000_0000, 32'd0);
        chk("ram_kept_00", o_r_data, 32'h0000_1234);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
